// File: rtl/spm_ctrl_pkg.sv
// Shared state encoding, default parameters and the no-wrap distance helper
// for the SPM offset move sequencer.
package spm_ctrl_pkg;

    localparam int SPM_DW          = 32;
    localparam int SPM_QDEPTH_LOG2 = 3;
    localparam int SPM_DWELL_W     = 24;
    localparam int SPM_SETTLE_CYC  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MOVE  = 3'd2,
        DWELL = 3'd3,
        ERROR = 3'd4
    } state_e;

    // |a - b| for signed operands, one bit wider than the inputs so it never wraps.
    function automatic logic [SPM_DW:0] abs_diff(input logic [SPM_DW-1:0] a,
                                                 input logic [SPM_DW-1:0] b);
        logic [SPM_DW:0] d;
        d = {a[SPM_DW-1], a} - {b[SPM_DW-1], b};
        if (d[SPM_DW]) begin
            abs_diff = {(SPM_DW+1){1'b0}} - d;
        end else begin
            abs_diff = d;
        end
    endfunction

endpackage

// File: rtl/spm_target_fifo.sv
// Synchronous FIFO holding pending move targets; read data is registered on pop
// and stays put until the next pop, flush empties the queue in one cycle.
module spm_target_fifo #(
    parameter int W  = 120,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          do_wr_s, do_rd_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = rd_data_q;

    // Pointer, level and read-data next state; a full queue never accepts a write.
    always_comb begin
        do_wr_s   = wr_en_i && !full_o && !flush_i;
        do_rd_s   = rd_en_i && !empty_o && !flush_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem_q[rd_ptr_q];
            end else begin
                rd_ptr_d  = rd_ptr_q;
                rd_data_d = rd_data_q;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk_i) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Control and read-data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/spm_offset_move_sequencer.sv
// Queued offset-move sequencer: applies pushed (x,y,z) targets one at a time, waits for the
// slew-limited offset monitors to settle, dwells, then reports completion.
module spm_offset_move_sequencer
    import spm_ctrl_pkg::*;
#(
    parameter int DW          = SPM_DW,
    parameter int QDEPTH_LOG2 = SPM_QDEPTH_LOG2,
    parameter int DWELL_W     = SPM_DWELL_W,
    parameter int SETTLE_CYC  = SPM_SETTLE_CYC
) (
    input  logic                   a_clk,
    input  logic                   a_resetn,
    input  logic [DW-1:0]          s_tgt_x,
    input  logic [DW-1:0]          s_tgt_y,
    input  logic [DW-1:0]          s_tgt_z,
    input  logic [DWELL_W-1:0]     s_tgt_dwell,
    input  logic                   s_tgt_valid,
    output logic                   s_tgt_ready,
    input  logic                   enable,
    input  logic                   abort,
    input  logic [DW-1:0]          tol,
    input  logic [31:0]            timeout,
    input  logic [DW-1:0]          mon_x0,
    input  logic [DW-1:0]          mon_y0,
    input  logic [DW-1:0]          mon_z0,
    output logic [DW-1:0]          x0,
    output logic [DW-1:0]          y0,
    output logic [DW-1:0]          z0,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   timeout_err,
    output logic [QDEPTH_LOG2:0]   q_level,
    output logic [15:0]            move_index
);

    localparam int FW = 3*DW + DWELL_W;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_e               state_q, state_d;
    logic [DW-1:0]        x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [31:0]          tmo_q, tmo_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [15:0]          idx_q, idx_d;
    logic                 rdy_en_q;

    logic                 fifo_wr_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [FW-1:0]        fifo_rd_data_s;
    logic [DW-1:0]        head_x_s, head_y_s, head_z_s;
    logic [DWELL_W-1:0]   head_dwell_s;
    logic [DW:0]          dx_s, dy_s, dz_s;
    logic                 in_tol_s;

    // Ready is held low until the first clock after reset release.
    assign s_tgt_ready = rdy_en_q && !fifo_full_s;
    assign fifo_wr_s   = s_tgt_valid && s_tgt_ready && !abort;

    spm_target_fifo #(
        .W  (FW),
        .AW (QDEPTH_LOG2)
    ) u_fifo (
        .clk_i     (a_clk),
        .rst_ni    (a_resetn),
        .flush_i   (abort),
        .wr_en_i   (fifo_wr_s),
        .wr_data_i ({s_tgt_x, s_tgt_y, s_tgt_z, s_tgt_dwell}),
        .rd_en_i   (fifo_pop_s),
        .rd_data_o (fifo_rd_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .level_o   (q_level)
    );

    // The popped entry stays in the FIFO read register for the whole move, dwell included.
    assign head_x_s     = fifo_rd_data_s[FW-1 -: DW];
    assign head_y_s     = fifo_rd_data_s[FW-DW-1 -: DW];
    assign head_z_s     = fifo_rd_data_s[FW-2*DW-1 -: DW];
    assign head_dwell_s = fifo_rd_data_s[DWELL_W-1:0];

    assign dx_s     = abs_diff(mon_x0, x0_q);
    assign dy_s     = abs_diff(mon_y0, y0_q);
    assign dz_s     = abs_diff(mon_z0, z0_q);
    assign in_tol_s = (dx_s <= {1'b0, tol}) && (dy_s <= {1'b0, tol}) && (dz_s <= {1'b0, tol});

    // Next-state and datapath decisions; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        z0_d       = z0_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        dwell_d    = dwell_q;
        err_d      = err_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        fifo_pop_s = 1'b0;
        if (abort) begin
            state_d = IDLE;
            x0_d    = mon_x0;
            y0_d    = mon_y0;
            z0_d    = mon_z0;
            err_d   = 1'b0;
            idx_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && !fifo_empty_s && !err_q) begin
                        fifo_pop_s = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    x0_d     = head_x_s;
                    y0_d     = head_y_s;
                    z0_d     = head_z_s;
                    settle_d = '0;
                    tmo_d    = 32'd0;
                    state_d  = MOVE;
                end
                MOVE: begin
                    if (settle_q == SW'(SETTLE_CYC)) begin
                        dwell_d = head_dwell_s;
                        state_d = DWELL;
                    end else if ((timeout != 32'd0) && (tmo_q == timeout)) begin
                        err_d   = 1'b1;
                        x0_d    = mon_x0;
                        y0_d    = mon_y0;
                        z0_d    = mon_z0;
                        state_d = ERROR;
                    end else begin
                        tmo_d    = tmo_q + 32'd1;
                        settle_d = in_tol_s ? (settle_q + SW'(1)) : '0;
                    end
                end
                DWELL: begin
                    if (dwell_q == '0) begin
                        done_d  = 1'b1;
                        idx_d   = idx_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // FSM state register.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            x0_q     <= '0;
            y0_q     <= '0;
            z0_q     <= '0;
            settle_q <= '0;
            tmo_q    <= 32'd0;
            dwell_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= 16'd0;
            rdy_en_q <= 1'b0;
        end else begin
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            z0_q     <= z0_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            dwell_q  <= dwell_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign x0          = x0_q;
    assign y0          = y0_q;
    assign z0          = z0_q;
    assign busy        = busy_q;
    assign done_pulse  = done_q;
    assign timeout_err = err_q;
    assign move_index  = idx_q;

endmodule

// File: tb/tb_spm_offset_move_sequencer.sv
// Directed bench for spm_offset_move_sequencer; completion events are checked by a
// scoreboard monitor, level/error/freeze behaviour by directed checks.
module tb_spm_offset_move_sequencer;

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic [31:0] s_tgt_x, s_tgt_y, s_tgt_z;
    logic [23:0] s_tgt_dwell;
    logic        s_tgt_valid, s_tgt_ready;
    logic        enable, abort;
    logic [31:0] tol, timeout;
    logic [31:0] mon_x0, mon_y0, mon_z0;
    logic [31:0] x0, y0, z0;
    logic        busy, done_pulse, timeout_err;
    logic [3:0]  q_level;
    logic [15:0] move_index;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [15:0] idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    spm_offset_move_sequencer dut (
        .a_clk       (a_clk),
        .a_resetn    (a_resetn),
        .s_tgt_x     (s_tgt_x),
        .s_tgt_y     (s_tgt_y),
        .s_tgt_z     (s_tgt_z),
        .s_tgt_dwell (s_tgt_dwell),
        .s_tgt_valid (s_tgt_valid),
        .s_tgt_ready (s_tgt_ready),
        .enable      (enable),
        .abort       (abort),
        .tol         (tol),
        .timeout     (timeout),
        .mon_x0      (mon_x0),
        .mon_y0      (mon_y0),
        .mon_z0      (mon_z0),
        .x0          (x0),
        .y0          (y0),
        .z0          (z0),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .timeout_err (timeout_err),
        .q_level     (q_level),
        .move_index  (move_index)
    );

    always #5 a_clk = ~a_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input logic [15:0] idx);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.z   = z;
        e.idx = idx;
        return e;
    endfunction

    // Scoreboard monitor: every done_pulse must match the oldest expected completion.
    always @(negedge a_clk) begin
        if (a_resetn && done_pulse) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done_pulse with move_index=%0d, expected none", move_index);
            end else begin
                sb_e = sb_q.pop_front();
                chk("done_x0", x0, sb_e.x);
                chk("done_y0", y0, sb_e.y);
                chk("done_z0", z0, sb_e.z);
                chk("done_move_index", move_index, sb_e.idx);
            end
        end
    end

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [23:0] d, output bit accepted);
        @(negedge a_clk);
        s_tgt_x     = x;
        s_tgt_y     = y;
        s_tgt_z     = z;
        s_tgt_dwell = d;
        s_tgt_valid = 1'b1;
        accepted    = s_tgt_ready;
        @(posedge a_clk);
        #1;
        s_tgt_valid = 1'b0;
    endtask

    task automatic pulse_abort(input bit with_push);
        @(negedge a_clk);
        abort = 1'b1;
        if (with_push) begin
            s_tgt_x     = 32'd99;
            s_tgt_y     = 32'd99;
            s_tgt_z     = 32'd99;
            s_tgt_dwell = 24'd0;
            s_tgt_valid = 1'b1;
        end
        @(posedge a_clk);
        #1;
        abort       = 1'b0;
        s_tgt_valid = 1'b0;
    endtask

    task automatic wait_x0(input string name, input logic [31:0] v);
        int n;
        n = 0;
        while (x0 !== v && n < 20) begin
            @(negedge a_clk);
            n++;
        end
        chk(name, (x0 === v), 1'b1);
    endtask

    initial begin
        bit acc;
        int n;
        a_resetn    = 1'b0;
        s_tgt_x     = 32'd0;
        s_tgt_y     = 32'd0;
        s_tgt_z     = 32'd0;
        s_tgt_dwell = 24'd0;
        s_tgt_valid = 1'b0;
        enable      = 1'b0;
        abort       = 1'b0;
        tol         = 32'd8;
        timeout     = 32'd0;
        mon_x0      = 32'd0;
        mon_y0      = 32'd0;
        mon_z0      = 32'd0;

        #12;
        chk("rst_x0", x0, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_pulse, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        chk("rst_level", q_level, 4'd0);
        chk("rst_index", move_index, 16'd0);
        chk("rst_ready", s_tgt_ready, 1'b0);
        @(negedge a_clk);
        a_resetn = 1'b1;
        #1;
        chk("ready_at_release", s_tgt_ready, 1'b0);
        @(negedge a_clk);
        chk("ready_after_release", s_tgt_ready, 1'b1);

        // Single move; monitors arrive exactly at tol after 100 cycles
        enable = 1'b1;
        sb_q.push_back(mk(32'd1000, 32'hFFFF_F830, 32'd50, 16'd1));
        push(32'd1000, 32'hFFFF_F830, 32'd50, 24'd10, acc);
        chk("t1_accept", acc, 1'b1);
        wait_x0("t1_load", 32'd1000);
        chk("t1_y0", y0, 32'hFFFF_F830);
        chk("t1_z0", z0, 32'd50);
        chk("t1_level", q_level, 4'd0);
        chk("t1_busy", busy, 1'b1);
        repeat (100) @(negedge a_clk);
        mon_x0 = 32'd1008;
        mon_y0 = 32'hFFFF_F830;
        mon_z0 = 32'd50;
        n = 100;
        while (!done_pulse && n < 400) begin
            @(negedge a_clk);
            n++;
        end
        chk("t1_done_latency_144", (n >= 140 && n <= 148), 1'b1);
        chk("t1_busy_fall", busy, 1'b0);

        // Fill the queue with enable low
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push(32'(i + 1), 32'd0, 32'd0, 24'd0, acc);
            chk("t2_accept", acc, (i < 8) ? 1'b1 : 1'b0);
        end
        chk("t2_level", q_level, 4'd8);
        chk("t2_ready_full", s_tgt_ready, 1'b0);
        pulse_abort(1'b1);
        @(negedge a_clk);
        chk("t2_abort_level", q_level, 4'd0);
        chk("t2_abort_ready", s_tgt_ready, 1'b1);
        chk("t2_abort_freeze_x0", x0, 32'd1008);
        chk("t2_abort_index", move_index, 16'd0);

        // Abort during dwell with three targets still queued
        push(32'd1008, 32'hFFFF_F830, 32'd50, 24'd200, acc);
        push(32'd1, 32'd1, 32'd1, 24'd0, acc);
        push(32'd2, 32'd2, 32'd2, 24'd0, acc);
        push(32'd3, 32'd3, 32'd3, 24'd0, acc);
        chk("t4_level_before", q_level, 4'd4);
        enable = 1'b1;
        repeat (100) @(negedge a_clk);
        chk("t4_level_in_dwell", q_level, 4'd3);
        chk("t4_busy_in_dwell", busy, 1'b1);
        mon_x0 = 32'd7;
        mon_y0 = 32'd8;
        mon_z0 = 32'd9;
        pulse_abort(1'b0);
        @(negedge a_clk);
        chk("t4_level", q_level, 4'd0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_x0", x0, 32'd7);
        chk("t4_y0", y0, 32'd8);
        chk("t4_z0", z0, 32'd9);

        // Out of tolerance by one LSB until the timeout fires
        tol     = 32'd4;
        timeout = 32'd500;
        mon_x0  = 32'd105;
        mon_y0  = 32'd200;
        mon_z0  = 32'd300;
        push(32'd100, 32'd200, 32'd300, 24'd0, acc);
        wait_x0("t3_load", 32'd100);
        n = 0;
        while (!timeout_err && n < 700) begin
            @(negedge a_clk);
            n++;
        end
        chk("t3_timeout_at_501", (n >= 498 && n <= 504), 1'b1);
        chk("t3_freeze_x0", x0, 32'd105);
        chk("t3_freeze_y0", y0, 32'd200);
        chk("t3_busy_error", busy, 1'b1);
        push(32'd1, 32'd1, 32'd1, 24'd0, acc);
        repeat (10) @(negedge a_clk);
        chk("t3_queue_retained", q_level, 4'd1);
        chk("t3_err_sticky", timeout_err, 1'b1);
        pulse_abort(1'b0);
        @(negedge a_clk);
        chk("t3_err_cleared", timeout_err, 1'b0);
        chk("t3_abort_level", q_level, 4'd0);

        // Near full-scale target vs monitor: 33-bit distance must not wrap into tolerance
        tol     = 32'h0000_0040;
        timeout = 32'd200;
        mon_x0  = 32'h8000_0010;
        mon_y0  = 32'd1;
        mon_z0  = 32'd2;
        push(32'h7FFF_FFF0, 32'd1, 32'd2, 24'd0, acc);
        wait_x0("t5_load", 32'h7FFF_FFF0);
        n = 0;
        while (!timeout_err && n < 400) begin
            @(negedge a_clk);
            n++;
        end
        chk("t5_not_settled", timeout_err, 1'b1);
        chk("t5_freeze_x0", x0, 32'h8000_0010);
        pulse_abort(1'b0);

        // Asynchronous reset in the middle of a move
        timeout = 32'd0;
        mon_x0  = 32'd0;
        mon_y0  = 32'd0;
        mon_z0  = 32'd0;
        enable  = 1'b0;
        push(32'd5000, 32'd6000, 32'd7000, 24'd0, acc);
        push(32'd11, 32'd12, 32'd13, 24'd0, acc);
        push(32'd21, 32'd22, 32'd23, 24'd0, acc);
        enable = 1'b1;
        wait_x0("t6_load", 32'd5000);
        chk("t6_level", q_level, 4'd2);
        #2;
        a_resetn = 1'b0;
        #1;
        chk("t6_rst_x0", x0, 32'd0);
        chk("t6_rst_y0", y0, 32'd0);
        chk("t6_rst_z0", z0, 32'd0);
        chk("t6_rst_level", q_level, 4'd0);
        chk("t6_rst_busy", busy, 1'b0);
        @(negedge a_clk);
        a_resetn = 1'b1;
        @(negedge a_clk);
        chk("t6_ready_after", s_tgt_ready, 1'b1);
        chk("t6_level_after", q_level, 4'd0);

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got no completion by 1 ms, expected end of stimulus");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
